// File: rtl/jk_pkg.sv
// Shared types and next-state helper
// for the JK flip-flop bank.
package jk_pkg;

  typedef enum logic [1:0] {
    JK_HOLD = 2'b00,
    JK_CLR  = 2'b01,
    JK_SET  = 2'b10,
    JK_TOG  = 2'b11
  } jk_op_t;

  localparam int JK_DEF_WIDTH = 1;

  function automatic logic jk_next(
    input logic cur,
    input logic j,
    input logic k
  );
    jk_op_t op;
    logic   nxt;
    op  = jk_op_t'({j, k});
    nxt = cur;
    unique case (op)
      JK_HOLD: nxt = cur;
      JK_CLR:  nxt = 1'b0;
      JK_SET:  nxt = 1'b1;
      JK_TOG:  nxt = ~cur;
      default: nxt = cur;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/jk_flipflop_if.sv
// J/K request and q/q_bar response bundle
// for a bank of JK flip-flops.
interface jk_flipflop_if
  import jk_pkg::*;
#(
  parameter int WIDTH = JK_DEF_WIDTH
);

  logic [WIDTH-1:0] j;
  logic [WIDTH-1:0] k;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] q_bar;

  modport master (
    output j,
    output k,
    input  q,
    input  q_bar
  );

  modport slave (
    input  j,
    input  k,
    output q,
    output q_bar
  );

endinterface

// File: rtl/jk_next_state.sv
// Combinational next-state logic
// for a single JK bit.
module jk_next_state
  import jk_pkg::*;
(
  input  logic cur,
  input  logic j,
  input  logic k,
  output logic nxt
);

  assign nxt = jk_next(cur, j, k);

endmodule

// File: rtl/jk_flipflop.sv
// WIDTH-bit JK flip-flop bank with
// synchronous active-low reset.
module jk_flipflop
  import jk_pkg::*;
#(
  parameter int               WIDTH       = JK_DEF_WIDTH,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] j,
  input  logic [WIDTH-1:0] k,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] q_bar
);

  logic [WIDTH-1:0] nxt;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    jk_next_state u_ns (
      .cur (q[i]),
      .j   (j[i]),
      .k   (k[i]),
      .nxt (nxt[i])
    );
  end

  // Reset is sampled only at the edge and overrides j/k.
  always_ff @(posedge clk) begin
    if (!reset) q <= RESET_VALUE;
    else        q <= nxt;
  end

  assign q_bar = ~q;

endmodule

// File: tb/tb_jk_flipflop.sv
// Directed self-checking bench for
// jk_flipflop at WIDTH=1 and WIDTH=4.
module tb_jk_flipflop;

  logic clk;
  logic rst1;
  logic rst4;

  int n_chk;
  int n_fail;

  jk_flipflop_if #(.WIDTH(1)) b1 ();
  jk_flipflop_if #(.WIDTH(4)) b4 ();

  jk_flipflop #(
    .WIDTH       (1),
    .RESET_VALUE (1'b0)
  ) u_w1 (
    .clk   (clk),
    .reset (rst1),
    .j     (b1.j),
    .k     (b1.k),
    .q     (b1.q),
    .q_bar (b1.q_bar)
  );

  jk_flipflop #(
    .WIDTH       (4),
    .RESET_VALUE (4'b0011)
  ) u_w4 (
    .clk   (clk),
    .reset (rst4),
    .j     (b4.j),
    .k     (b4.k),
    .q     (b4.q),
    .q_bar (b4.q_bar)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk1(
    input string tag,
    input logic  exp
  );
    check({tag, ".q"}, {31'b0, b1.q},
          {31'b0, exp});
    check({tag, ".qb"}, {31'b0, b1.q_bar},
          {31'b0, ~exp});
  endtask

  task automatic chk4(
    input string      tag,
    input logic [3:0] exp
  );
    check({tag, ".q"}, {28'b0, b4.q},
          {28'b0, exp});
    check({tag, ".qb"}, {28'b0, b4.q_bar},
          {28'b0, ~exp});
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    rst1   = 1'b0;
    rst4   = 1'b0;
    b1.j   = 1'b0;
    b1.k   = 1'b0;
    b4.j   = 4'b0000;
    b4.k   = 4'b0000;

    step();
    chk1("rst", 1'b0);
    b1.j = 1'b1;
    b1.k = 1'b1;
    step();
    chk1("rst_dom", 1'b0);

    rst1 = 1'b1;
    b1.k = 1'b0;
    step();
    chk1("set", 1'b1);
    b1.j = 1'b0;
    step();
    chk1("hold1", 1'b1);
    step();
    chk1("hold2", 1'b1);

    b1.k = 1'b1;
    step();
    chk1("clr", 1'b0);
    b1.j = 1'b1;
    step();
    chk1("tog1", 1'b1);
    step();
    chk1("tog2", 1'b0);
    step();
    chk1("tog3", 1'b1);
    step();
    chk1("tog4", 1'b0);

    b1.k = 1'b0;
    step();
    chk1("set2", 1'b1);
    b1.j = 1'b0;
    step();
    chk1("hold3", 1'b1);

    b1.j = 1'b1;
    b1.k = 1'b1;
    #2;
    b1.j = 1'b0;
    b1.k = 1'b0;
    step();
    chk1("glitch", 1'b1);

    rst1 = 1'b0;
    #2;
    rst1 = 1'b1;
    step();
    chk1("rst_pulse", 1'b1);

    rst1 = 1'b0;
    b1.j = 1'b1;
    step();
    chk1("rst_mid", 1'b0);
    rst1 = 1'b1;
    step();
    chk1("rst_rel", 1'b1);

    chk4("w4_rst", 4'b0011);
    rst4 = 1'b1;
    b4.j = 4'b1010;
    b4.k = 4'b0110;
    step();
    chk4("w4_mix", 4'b1001);
    b4.j = 4'b1111;
    b4.k = 4'b1111;
    step();
    chk4("w4_tog", 4'b0110);
    b4.j = 4'b0000;
    b4.k = 4'b0000;
    step();
    chk4("w4_hold", 4'b0110);
    rst4 = 1'b0;
    b4.j = 4'b1111;
    b4.k = 4'b1111;
    step();
    chk4("w4_rst2", 4'b0011);
    rst4 = 1'b1;
    b4.j = 4'b0001;
    b4.k = 4'b1000;
    step();
    chk4("w4_rel", 4'b0011);
    b4.j = 4'b0100;
    b4.k = 4'b0011;
    step();
    chk4("w4_mix2", 4'b0100);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/jk_flipflop.md
Name: jk_flipflop

Overview:
- Clocked JK flip-flop storage element for the latches-and-flops library.
- Updates its state on the rising clock edge from the J/K inputs: hold, clear, set or toggle.
- Provides true output q and complementary output q_bar.
- Parameterised width: a bank of WIDTH independent JK bits sharing one clock and one reset; the default is a single bit.

Parameters:
- WIDTH, 1, number of independent JK bits (bit i of q depends only on bit i of j and k).
- RESET_VALUE, {WIDTH{1'b0}}, value loaded into q while reset is asserted.

Ports:
- clk  input  1  clock; all state changes occur on the rising edge.
- reset  input  1  synchronous, active-low reset. 0 means reset asserted; it is sampled only on the rising edge of clk.
- j  input  WIDTH  set request, per bit.
- k  input  WIDTH  clear request, per bit.
- q  output  WIDTH  registered state.
- q_bar  output  WIDTH  bitwise complement of q.
- Positional port order is exactly clk, reset, j, k, q, q_bar. Positional instantiation must work.

Behaviour:
- One clock; reset is synchronous and active-low. No asynchronous path exists: reset has no effect between clock edges.
- On each rising edge of clk, when reset==0: q <= RESET_VALUE. Reset dominates j and k, including j=k=1.
- On each rising edge of clk, when reset==1, per bit i:
  - {j,k}=00: hold, q[i] keeps its value.
  - {j,k}=01: clear, q[i] <= 0.
  - {j,k}=10: set, q[i] <= 1.
  - {j,k}=11: toggle, q[i] <= ~q[i].
- q_bar is combinational and always equals ~q, on the same timestep as q. Never drive q_bar from a separate register.
- Latency: one clock edge. q reflects the j/k/reset values sampled at the most recent rising edge. Input changes between edges have no effect.
- Power-up: q is undefined (X in simulation) until the first rising edge sampled with reset==0. No initial value is required in RTL.
- Reset mid-operation: the first edge with reset==0 forces RESET_VALUE regardless of current state or j/k.
- Reset release: the first edge with reset==1 applies the j/k function to RESET_VALUE.
- Continuous toggle (j=k=1, reset=1) alternates q every rising edge. It does not race or oscillate, because the design is edge-triggered.
- j/k are assumed stable around the rising edge. No synchronisers are included.

Decomposition:
- Shared package jk_pkg:
  - 2-bit typedef jk_op_t with constants JK_HOLD=2'b00, JK_CLR=2'b01, JK_SET=2'b10, JK_TOG=2'b11.
  - Helper function jk_next(cur, j, k) returning the next-state bit.
- One natural sub-module, jk_next_state: purely combinational next-state logic for one bit, replicated WIDTH times via generate.
- The top level holds the WIDTH-bit register with synchronous reset and the q_bar inversion.

Test Plan:
- Apply reset=0, j=0, k=0 for one edge -> q=0, q_bar=1. Then hold reset=0 with j=1, k=1 for one edge -> q stays 0 (reset dominates).
- Set reset=1, j=1, k=0, one edge -> q=1, q_bar=0. Then j=0, k=0 for two edges -> q stays 1.
- From q=1, apply j=0, k=1 -> q=0 after the next edge. Then j=1, k=1 for four edges -> q toggles 1,0,1,0.
- Change j/k mid-cycle with reset=1 and restore them before the edge -> q unchanged. Pulse reset=0 between edges only -> q unchanged (synchronous reset).
- From q=1, drive reset=0 with j=1, k=0 -> q=0 on that edge. Release reset=1, keeping j=1, k=0 -> q=1 on the next edge.
- WIDTH=4: drive j=4'b1010, k=4'b0110 from q=4'b0011 -> q=4'b1001. At every sample, assert q_bar==~q.
